// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU request port and a 16K x 32 single-port RAM.
// Byte and halfword stores are performed as read-merge-write of the containing word.
module mem_access_unit #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Write,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [15:0] ByteAddr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        AddrError,
    output logic [31:0] LoadData,
    output logic [13:0] RamAddress,
    output logic        RamMemWrite,
    output logic [31:0] RamWriteData,
    input  logic [31:0] RamReadData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state, next_state;
    logic        write_q, unsigned_q, error_q;
    logic [1:0]  size_q;
    logic [15:0] addr_q;
    logic [31:0] store_q, old_q, load_q;
    logic        misaligned;
    logic [4:0]  byte_shift, half_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] merged, extracted;

    assign misaligned = (Size == 2'b11)
                     || (Size == SZ_HALF && ByteAddr[0])
                     || (Size == SZ_WORD && ByteAddr[1:0] != 2'b00);

    // Lane 0 sits in the top byte when big-endian, so the lane index is inverted.
    assign byte_shift = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
    assign half_shift = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
    assign rd_byte    = 8'(RamReadData >> byte_shift);
    assign rd_half    = 16'(RamReadData >> half_shift);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Req) begin
                    if (misaligned)                     next_state = DONE;
                    else if (Write && Size == SZ_WORD) next_state = WRITE;
                    else                                next_state = READ;
                end
            end
            READ:    next_state = write_q ? WRITE : DONE;
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        merged    = store_q;
        extracted = RamReadData;
        case (size_q)
            SZ_BYTE: begin
                merged    = (old_q & ~(32'h0000_00FF << byte_shift))
                          | ({24'h0, store_q[7:0]} << byte_shift);
                extracted = unsigned_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SZ_HALF: begin
                merged    = (old_q & ~(32'h0000_FFFF << half_shift))
                          | ({16'h0, store_q[15:0]} << half_shift);
                extracted = unsigned_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            default: begin
                merged    = store_q;
                extracted = RamReadData;
            end
        endcase
    end

    // Request fields are captured only on acceptance; READ captures the RAM word.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            error_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= 16'h0;
            store_q    <= 32'h0;
            old_q      <= 32'h0;
            load_q     <= 32'h0;
        end else begin
            if (state == IDLE && Req) begin
                write_q    <= Write;
                unsigned_q <= Unsigned;
                size_q     <= Size;
                addr_q     <= ByteAddr;
                store_q    <= StoreData;
                error_q    <= misaligned;
            end
            if (state == READ) begin
                old_q <= RamReadData;
                if (!write_q) load_q <= extracted;
            end
        end
    end

    always_comb begin
        Busy         = 1'b0;
        Done         = 1'b0;
        AddrError    = 1'b0;
        RamAddress   = 14'h0;
        RamMemWrite  = 1'b0;
        RamWriteData = 32'h0;
        case (state)
            IDLE: ;
            READ: begin
                Busy       = 1'b1;
                RamAddress = addr_q[15:2];
            end
            WRITE: begin
                Busy         = 1'b1;
                RamAddress   = addr_q[15:2];
                RamMemWrite  = 1'b1;
                RamWriteData = merged;
            end
            DONE: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                AddrError = error_q;
            end
            default: ;
        endcase
    end

    assign LoadData = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 16K x 32 RAM behind it.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Req, Write, Unsigned;
    logic [1:0]  Size;
    logic [15:0] ByteAddr;
    logic [31:0] StoreData;
    logic        Busy, Done, AddrError, RamMemWrite;
    logic [31:0] LoadData, RamWriteData, RamReadData;
    logic [13:0] RamAddress;

    logic [31:0] ram [0:16383];
    int          wr_count = 0;
    logic [13:0] last_wr_addr = 14'h0;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.BIG_ENDIAN(1'b1)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Write(Write), .Size(Size),
        .Unsigned(Unsigned), .ByteAddr(ByteAddr), .StoreData(StoreData),
        .Busy(Busy), .Done(Done), .AddrError(AddrError), .LoadData(LoadData),
        .RamAddress(RamAddress), .RamMemWrite(RamMemWrite),
        .RamWriteData(RamWriteData), .RamReadData(RamReadData)
    );

    always #5 Clock = ~Clock;

    assign RamReadData = ram[RamAddress];

    always @(posedge Clock) begin
        if (RamMemWrite) begin
            ram[RamAddress] <= RamWriteData;
            wr_count        = wr_count + 1;
            last_wr_addr    = RamAddress;
        end
    end

    // One request with Req dropped after the sample edge; lat counts edges up to Done.
    task automatic do_access(input logic w, input logic [1:0] sz, input logic u,
                             input logic [15:0] a, input logic [31:0] sd,
                             output int lat, output logic err, output logic done_after);
        logic seen;
        @(negedge Clock);
        Write = w; Size = sz; Unsigned = u; ByteAddr = a; StoreData = sd; Req = 1'b1;
        lat = 0; err = 1'b0; seen = 1'b0;
        while (!seen && lat < 8) begin
            @(posedge Clock); #1;
            lat++;
            Req = 1'b0;
            if (Done) begin seen = 1'b1; err = AddrError; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL timeout addr %h: no Done within %0d cycles", a, lat);
        end
        @(posedge Clock); #1;
        done_after = Done;
    endtask

    task automatic test_reset();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", Done); end
        checks++; if (AddrError !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", AddrError); end
        checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL reset_load got %h expected 0", LoadData); end
        checks++; if (RamMemWrite !== 1'b0) begin errors++; $display("FAIL reset_we got %b expected 0", RamMemWrite); end
        checks++; if (RamAddress !== 14'h0) begin errors++; $display("FAIL reset_addr got %h expected 0", RamAddress); end
        checks++; if (RamWriteData !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h expected 0", RamWriteData); end
    endtask

    task automatic test_word();
        int lat; logic err, da; int wc;
        wc = wr_count;
        do_access(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, lat, err, da);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat got %0d expected 2", lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL word_store_err got %b expected 0", err); end
        checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL word_store_writes got %0d expected 1", wr_count - wc); end
        checks++; if (last_wr_addr !== 14'd4) begin errors++; $display("FAIL word_store_addr got %h expected 4", last_wr_addr); end
        checks++; if (ram[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_ram got %h expected deadbeef", ram[4]); end
        wc = wr_count;
        do_access(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, lat, err, da);
        checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat got %0d expected 2", lat); end
        checks++; if (LoadData !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load got %h expected deadbeef", LoadData); end
        checks++; if (wr_count !== wc) begin errors++; $display("FAIL word_load_writes got %0d expected 0", wr_count - wc); end
    endtask

    task automatic test_subword_store();
        int lat; logic err, da; int wc;
        do_access(1'b1, 2'b10, 1'b0, 16'h0020, 32'h11223344, lat, err, da);
        wc = wr_count;
        do_access(1'b1, 2'b00, 1'b0, 16'h0021, 32'h000000AA, lat, err, da);
        checks++; if (lat !== 3) begin errors++; $display("FAIL byte_store_lat got %0d expected 3", lat); end
        checks++; if (wr_count - wc !== 1) begin errors++; $display("FAIL byte_store_writes got %0d expected 1", wr_count - wc); end
        checks++; if (ram[8] !== 32'h11AA3344) begin errors++; $display("FAIL byte_store_ram got %h expected 11aa3344", ram[8]); end
        do_access(1'b1, 2'b01, 1'b0, 16'h0022, 32'h1234BEEF, lat, err, da);
        checks++; if (lat !== 3) begin errors++; $display("FAIL half_store_lat got %0d expected 3", lat); end
        checks++; if (ram[8] !== 32'h11AABEEF) begin errors++; $display("FAIL half_store_ram got %h expected 11aabeef", ram[8]); end
    endtask

    task automatic test_loads();
        int lat; logic err, da;
        do_access(1'b1, 2'b10, 1'b0, 16'h0030, 32'h80FF7F01, lat, err, da);
        do_access(1'b0, 2'b00, 1'b0, 16'h0030, 32'h0, lat, err, da);
        checks++; if (LoadData !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h expected ffffff80", LoadData); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL lb_lat got %0d expected 2", lat); end
        do_access(1'b0, 2'b00, 1'b1, 16'h0030, 32'h0, lat, err, da);
        checks++; if (LoadData !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h expected 00000080", LoadData); end
        do_access(1'b0, 2'b01, 1'b0, 16'h0032, 32'h0, lat, err, da);
        checks++; if (LoadData !== 32'h00007F01) begin errors++; $display("FAIL lh_signed_hi got %h expected 00007f01", LoadData); end
        do_access(1'b0, 2'b01, 1'b0, 16'h0030, 32'h0, lat, err, da);
        checks++; if (LoadData !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_signed_lo got %h expected ffff80ff", LoadData); end
        do_access(1'b0, 2'b00, 1'b1, 16'h0033, 32'h0, lat, err, da);
        checks++; if (LoadData !== 32'h00000001) begin errors++; $display("FAIL lb_lane3 got %h expected 00000001", LoadData); end
    endtask

    task automatic test_misaligned();
        int lat; logic err, da; int wc;
        wc = wr_count;
        do_access(1'b1, 2'b01, 1'b0, 16'h0041, 32'hFFFF, lat, err, da);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_half_lat got %0d expected 1", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_half_err got %b expected 1", err); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL mis_half_done_len got %b expected 0", da); end
        do_access(1'b0, 2'b10, 1'b0, 16'h0042, 32'h0, lat, err, da);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_word_lat got %0d expected 1", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_word_err got %b expected 1", err); end
        checks++; if (LoadData !== 32'h00000001) begin errors++; $display("FAIL mis_word_load got %h expected 00000001", LoadData); end
        do_access(1'b0, 2'b11, 1'b0, 16'h0000, 32'h0, lat, err, da);
        checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL size11 got lat %0d err %b expected 1 1", lat, err); end
        checks++; if (AddrError !== 1'b0) begin errors++; $display("FAIL size11_err_len got %b expected 0", AddrError); end
        checks++; if (wr_count !== wc) begin errors++; $display("FAIL mis_writes got %0d expected 0", wr_count - wc); end
    endtask

    task automatic test_reset_mid();
        int lat; logic err, da; int wc; logic seen_done;
        do_access(1'b1, 2'b10, 1'b0, 16'h0050, 32'h55667788, lat, err, da);
        @(negedge Clock);
        Write = 1'b1; Size = 2'b00; Unsigned = 1'b0; ByteAddr = 16'h0051; StoreData = 32'h99; Req = 1'b1;
        @(posedge Clock); #1;
        Req = 1'b0;
        checks++; if (Busy !== 1'b1 || RamAddress !== 14'h14) begin errors++; $display("FAIL mid_read got busy %b addr %h expected 1 14", Busy, RamAddress); end
        wc = wr_count;
        #2; Reset_n = 1'b0; #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || AddrError !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got %b%b%b expected 000", Busy, Done, AddrError); end
        checks++; if (LoadData !== 32'h0) begin errors++; $display("FAIL mid_rst_load got %h expected 0", LoadData); end
        checks++; if (RamAddress !== 14'h0 || RamMemWrite !== 1'b0 || RamWriteData !== 32'h0) begin errors++; $display("FAIL mid_rst_ram got %h %b %h expected 0 0 0", RamAddress, RamMemWrite, RamWriteData); end
        seen_done = 1'b0;
        repeat (3) begin @(posedge Clock); #1; if (Done) seen_done = 1'b1; end
        @(negedge Clock); Reset_n = 1'b1;
        repeat (2) begin @(posedge Clock); #1; if (Done) seen_done = 1'b1; end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b expected 0", seen_done); end
        checks++; if (wr_count !== wc || ram[14'h14] !== 32'h55667788) begin errors++; $display("FAIL mid_rst_ram_word got %h expected 55667788", ram[14'h14]); end
        do_access(1'b0, 2'b10, 1'b0, 16'h0050, 32'h0, lat, err, da);
        checks++; if (lat !== 2 || LoadData !== 32'h55667788) begin errors++; $display("FAIL post_rst_load got lat %0d data %h expected 2 55667788", lat, LoadData); end
    endtask

    task automatic test_back_to_back();
        int wc;
        wc = wr_count;
        @(negedge Clock);
        Write = 1'b0; Size = 2'b10; Unsigned = 1'b0; ByteAddr = 16'h0020; StoreData = 32'h0; Req = 1'b1;
        @(posedge Clock); #1;
        Write = 1'b1; ByteAddr = 16'h0060; StoreData = 32'hCAFEF00D;
        checks++; if (Busy !== 1'b1 || Done !== 1'b0 || RamMemWrite !== 1'b0) begin errors++; $display("FAIL b2b_c1 got busy %b done %b we %b expected 1 0 0", Busy, Done, RamMemWrite); end
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b1 || LoadData !== 32'h11AABEEF) begin errors++; $display("FAIL b2b_c2 got done %b data %h expected 1 11aabeef", Done, LoadData); end
        @(posedge Clock); #1;
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_c3_idle got busy %b expected 0", Busy); end
        @(posedge Clock); #1;
        Req = 1'b0;
        checks++; if (RamMemWrite !== 1'b1 || RamAddress !== 14'h18 || RamWriteData !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_c4_write got %b %h %h expected 1 18 cafef00d", RamMemWrite, RamAddress, RamWriteData); end
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b1 || AddrError !== 1'b0) begin errors++; $display("FAIL b2b_c5 got done %b err %b expected 1 0", Done, AddrError); end
        @(posedge Clock); #1;
        checks++; if (Busy !== 1'b0 || wr_count - wc !== 1 || ram[14'h18] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_end got busy %b writes %0d ram %h expected 0 1 cafef00d", Busy, wr_count - wc, ram[14'h18]); end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        Reset_n = 1'b0; Req = 1'b0; Write = 1'b0; Size = 2'b00; Unsigned = 1'b0;
        ByteAddr = 16'h0; StoreData = 32'h0;
        repeat (2) @(negedge Clock);
        test_reset();
        Reset_n = 1'b1;
        test_word();
        test_subword_store();
        test_loads();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
